// File: rtl/fpga_mem_responder.sv
// rtl/fpga_mem_responder.sv - NoC-side memory target answering noc2 requests with noc3 responses
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   noc2_in_*       request flits in (val/rdy); 3 header flits plus write data
//   noc3_out_*      response flits out (val/rdy); write ack or read header + burst
//   busy            high whenever a request or its response is in progress
module fpga_mem_responder #(
    parameter int NOC_DATA_WIDTH = 64,
    parameter int MEM_ADDR_WIDTH = 8,
    parameter int ADDR_LSB       = 3,
    parameter int RD_DATA_FLITS  = 32,
    parameter int LEN_HI         = 29,
    parameter int LEN_LO         = 22,
    parameter int MSHRID_HI      = 13,
    parameter int MSHRID_LO      = 6
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      noc2_in_val,
    input  logic [NOC_DATA_WIDTH-1:0] noc2_in_data,
    output logic                      noc2_in_rdy,
    output logic                      noc3_out_val,
    output logic [NOC_DATA_WIDTH-1:0] noc3_out_data,
    input  logic                      noc3_out_rdy,
    output logic                      busy
);

    localparam int LEN_W = LEN_HI - LEN_LO + 1;
    localparam int TAG_W = MSHRID_HI - MSHRID_LO + 1;
    localparam int DEPTH = 1 << MEM_ADDR_WIDTH;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_HDR2    = 3'd1;
    localparam logic [2:0] S_HDR3    = 3'd2;
    localparam logic [2:0] S_WR_DATA = 3'd3;
    localparam logic [2:0] S_WR_ACK  = 3'd4;
    localparam logic [2:0] S_RD_HDR  = 3'd5;
    localparam logic [2:0] S_RD_DATA = 3'd6;

    logic [2:0]                state_q, state_d;
    logic [LEN_W-1:0]          len_q, len_d;
    logic [TAG_W-1:0]          tag_q, tag_d;
    logic [7:0]                rem_q, rem_d;
    logic [7:0]                cnt_q, cnt_d;
    logic [MEM_ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic                      mem_we;
    logic                      in_fire;
    logic                      out_fire;

    logic [NOC_DATA_WIDTH-1:0] mem_q [DEPTH];

    assign noc2_in_rdy  = (state_q == S_IDLE) || (state_q == S_HDR2) ||
                          (state_q == S_HDR3) || (state_q == S_WR_DATA);
    assign noc3_out_val = (state_q == S_WR_ACK) || (state_q == S_RD_HDR) ||
                          (state_q == S_RD_DATA);
    assign busy         = (state_q != S_IDLE);
    assign in_fire      = noc2_in_val && noc2_in_rdy;
    assign out_fire     = noc3_out_val && noc3_out_rdy;

    // Response data is zero outside the response states so the bus is clean when idle.
    always_comb begin
        noc3_out_data = '0;
        case (state_q)
            S_WR_ACK: begin
                noc3_out_data[MSHRID_HI:MSHRID_LO] = tag_q;
            end
            S_RD_HDR: begin
                noc3_out_data[LEN_HI:LEN_LO]       = LEN_W'(RD_DATA_FLITS);
                noc3_out_data[MSHRID_HI:MSHRID_LO] = tag_q;
            end
            S_RD_DATA: noc3_out_data = mem_q[ptr_q];
            default:   noc3_out_data = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        tag_d   = tag_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        mem_we  = 1'b0;
        case (state_q)
            S_IDLE: if (in_fire) begin
                len_d = noc2_in_data[LEN_HI:LEN_LO];
                tag_d = noc2_in_data[MSHRID_HI:MSHRID_LO];
                // len==0 is a one-flit packet: it is fully consumed here.
                state_d = (noc2_in_data[LEN_HI:LEN_LO] == '0) ? S_IDLE : S_HDR2;
            end
            S_HDR2: if (in_fire) begin
                ptr_d   = noc2_in_data[ADDR_LSB +: MEM_ADDR_WIDTH];
                state_d = (len_q < LEN_W'(2)) ? S_IDLE : S_HDR3;
            end
            S_HDR3: if (in_fire) begin
                if (len_q == LEN_W'(2)) begin
                    state_d = S_RD_HDR;
                end else begin
                    rem_d   = 8'(len_q - LEN_W'(2));
                    state_d = S_WR_DATA;
                end
            end
            S_WR_DATA: if (in_fire) begin
                mem_we = 1'b1;
                ptr_d  = ptr_q + 1'b1;
                rem_d  = rem_q - 8'd1;
                if (rem_q == 8'd1) state_d = S_WR_ACK;
            end
            S_WR_ACK: if (out_fire) state_d = S_IDLE;
            S_RD_HDR: if (out_fire) begin
                cnt_d   = 8'd0;
                state_d = S_RD_DATA;
            end
            S_RD_DATA: if (out_fire) begin
                ptr_d = ptr_q + 1'b1;
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == 8'(RD_DATA_FLITS - 1)) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            tag_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            tag_q   <= tag_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
        end
    end

    // Memory is deliberately outside the reset domain so contents survive a reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[ptr_q] <= noc2_in_data;
    end

endmodule

// File: tb/tb_fpga_mem_responder.sv
// tb/tb_fpga_mem_responder.sv - self-checking bench for fpga_mem_responder
module tb_fpga_mem_responder;

    localparam int TMO = 200;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        noc2_in_val;
    logic [63:0] noc2_in_data;
    logic        noc2_in_rdy;
    logic        noc3_out_val;
    logic [63:0] noc3_out_data;
    logic        noc3_out_rdy;
    logic        busy;

    int tests = 0;
    int fails = 0;
    int out_xfers = 0;

    logic [63:0] model_mem [256];

    fpga_mem_responder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .noc2_in_val  (noc2_in_val),
        .noc2_in_data (noc2_in_data),
        .noc2_in_rdy  (noc2_in_rdy),
        .noc3_out_val (noc3_out_val),
        .noc3_out_data(noc3_out_data),
        .noc3_out_rdy (noc3_out_rdy),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (noc3_out_val && noc3_out_rdy) out_xfers++;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] hdr(input logic [7:0] len, input logic [7:0] tag);
        logic [63:0] f;
        f = '0;
        f[29:22] = len;
        f[13:6]  = tag;
        return f;
    endfunction

    // Address flit with junk above and below the word index.
    function automatic logic [63:0] addr_flit(input int word);
        logic [63:0] f;
        f = {$urandom, $urandom};
        f[10:3] = word[7:0];
        return f;
    endfunction

    task automatic send(input logic [63:0] d, input bit gap);
        int t = 0;
        if (gap) begin
            noc2_in_val  = 1'b0;
            noc2_in_data = {$urandom, $urandom};
            @(negedge clk);
        end
        noc2_in_val  = 1'b1;
        noc2_in_data = d;
        while (!noc2_in_rdy && t < TMO) begin
            @(negedge clk);
            t++;
        end
        chk("send_timeout", 64'(t < TMO), 64'd1);
        @(negedge clk);
        noc2_in_val  = 1'b0;
        noc2_in_data = '0;
    endtask

    task automatic recv(input string name, input logic [63:0] exp, input int stall);
        int t = 0;
        noc3_out_rdy = 1'b0;
        while (!noc3_out_val && t < TMO) begin
            @(negedge clk);
            t++;
        end
        chk({name, "_timeout"}, 64'(t < TMO), 64'd1);
        for (int s = 0; s < stall; s++) begin
            chk({name, "_hold_val"}, 64'(noc3_out_val), 64'd1);
            chk({name, "_hold_data"}, noc3_out_data, exp);
            @(negedge clk);
        end
        chk(name, noc3_out_data, exp);
        chk({name, "_in_rdy_low"}, 64'(noc2_in_rdy), 64'd0);
        noc3_out_rdy = 1'b1;
        @(negedge clk);
        noc3_out_rdy = 1'b0;
    endtask

    task automatic send_req(input logic [7:0] len, input logic [7:0] tag, input int word, input bit gap);
        send(hdr(len, tag), gap);
        if (len != 0) send(addr_flit(word), gap);
        if (len >= 2) send({$urandom, $urandom}, gap);
    endtask

    task automatic do_write(input int word, input logic [7:0] tag, input logic [63:0] dq[$], input bit gap);
        send_req(8'(dq.size() + 2), tag, word, gap);
        foreach (dq[i]) begin
            model_mem[(word + i) % 256] = dq[i];
            send(dq[i], gap);
        end
        recv("wr_ack", hdr(8'd0, tag), 0);
        chk("wr_idle", 64'(busy), 64'd0);
    endtask

    task automatic do_read(input int word, input logic [7:0] tag, input int stall_hdr,
                           input int stall_idx, input int nflits);
        int x0;
        send_req(8'd2, tag, word, 1'b0);
        x0 = out_xfers;
        recv("rd_hdr", hdr(8'd32, tag), stall_hdr);
        for (int i = 0; i < nflits; i++)
            recv("rd_data", model_mem[(word + i) % 256], (i == stall_idx) ? 5 : 0);
        if (nflits == 32) begin
            chk("rd_xfers", 64'(out_xfers - x0), 64'd33);
            chk("rd_idle", 64'(busy), 64'd0);
        end
    endtask

    function automatic void rand_q(output logic [63:0] q[$], input int n);
        q = {};
        for (int i = 0; i < n; i++) q.push_back({$urandom, $urandom});
    endfunction

    initial begin
        logic [63:0] dq[$];
        rst_n        = 1'b0;
        noc2_in_val  = 1'b0;
        noc2_in_data = '0;
        noc3_out_rdy = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_rdy", 64'(noc2_in_rdy), 64'd1);
        chk("rst_out_val", 64'(noc3_out_val), 64'd0);
        chk("rst_out_data", noc3_out_data, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Fill the whole array so every later read has a known expectation.
        rand_q(dq, 128); do_write(0, 8'h01, dq, 1'b0);
        rand_q(dq, 128); do_write(128, 8'h02, dq, 1'b0);

        // Write then read.
        dq = {};
        dq.push_back(64'hA0A0_A0A0_0000_00A0);
        dq.push_back(64'hA1A1_A1A1_0000_00A1);
        do_write(8, 8'h15, dq, 1'b0);
        do_read(8, 8'h22, 0, -1, 32);

        // Wrap at the top of the array.
        dq = {};
        dq.push_back(64'hB0B0_B0B0_0000_00B0);
        dq.push_back(64'hB1B1_B1B1_0000_00B1);
        do_write(255, 8'h33, dq, 1'b0);
        do_read(255, 8'h34, 0, -1, 32);

        // Output backpressure on header and data flit 3.
        do_read(40, 8'h44, 5, 3, 32);

        // Input stalls through a len=6 write, then read back.
        rand_q(dq, 4);
        do_write(100, 8'h55, dq, 1'b1);
        do_read(100, 8'h56, 0, -1, 32);

        // Malformed len=0 then back-to-back read.
        send(hdr(8'd0, 8'h66), 1'b0);
        chk("len0_busy", 64'(busy), 64'd0);
        chk("len0_val", 64'(noc3_out_val), 64'd0);
        do_read(200, 8'h67, 0, -1, 32);

        // Malformed len=1: two flits consumed, no response.
        send(hdr(8'd1, 8'h68), 1'b0);
        chk("len1_busy_mid", 64'(busy), 64'd1);
        send(addr_flit(3), 1'b0);
        chk("len1_busy", 64'(busy), 64'd0);
        chk("len1_val", 64'(noc3_out_val), 64'd0);
        repeat (3) @(negedge clk);
        chk("len1_val_later", 64'(noc3_out_val), 64'd0);

        // Reset in the middle of a read burst.
        do_read(60, 8'h77, 0, -1, 10);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_val", 64'(noc3_out_val), 64'd0);
        chk("mid_rst_data", noc3_out_data, 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_rdy", 64'(noc2_in_rdy), 64'd1);
        chk("post_rst_val", 64'(noc3_out_val), 64'd0);
        do_read(60, 8'h78, 0, -1, 32);

        // Randomized write/read pairs against the array model.
        for (int it = 0; it < 20; it++) begin
            rand_q(dq, $urandom_range(1, 8));
            do_write($urandom_range(0, 255), 8'($urandom), dq, 1'($urandom));
            do_read($urandom_range(0, 255), 8'($urandom), $urandom_range(0, 2),
                    $urandom_range(0, 40), 32);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fpga_mem_responder.md
Name: fpga_mem_responder

Overview:
- NoC-side memory target: the responder end of the request/response protocol used by the FPGA LSU memory bridge.
- Consumes request packets on the noc2 channel: three header flits, plus data flits for writes.
- Services each request from an internal word-addressed memory array with asynchronous (combinational) read and synchronous write.
- Returns a single-flit write ack or a read response (header + fixed data burst) on the noc3 channel; serves as an on-FPGA memory model and bring-up target.

Parameters:
- NOC_DATA_WIDTH, 64, flit width.
- MEM_ADDR_WIDTH, 8, log2 of array depth in NOC_DATA_WIDTH-bit words (256).
- ADDR_LSB, 3, byte-to-word shift; word index = flit2[ADDR_LSB +: MEM_ADDR_WIDTH].
- RD_DATA_FLITS, 32, data flits per read response (2048 bits).
- LEN_HI, 29, MSB of the length field in header flit 1.
- LEN_LO, 22, LSB of the length field.
- MSHRID_HI, 13, MSB of the tag field in header flit 1.
- MSHRID_LO, 6, LSB of the tag field.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- noc2_in_val  in  1  request flit valid
- noc2_in_data  in  NOC_DATA_WIDTH  request flit
- noc2_in_rdy  out  1  responder accepts request flit
- noc3_out_val  out  1  response flit valid
- noc3_out_data  out  NOC_DATA_WIDTH  response flit
- noc3_out_rdy  in  1  downstream accepts response flit
- busy  out  1  state != IDLE

Behaviour:
- One clock (clk); reset (rst_n) is asynchronous and active-low.
- Reset: state=IDLE; noc2_in_rdy=1 (IDLE); noc3_out_val=0, noc3_out_data=0, busy=0; all counters and latches cleared. Memory contents are not reset.
- Handshake: a flit transfers in a cycle where val&&rdy. noc3_out_data must be 0 whenever noc3_out_val=0. noc3_out_val never drops without a transfer.
- Request format:
  - flit1: len = flit1[LEN_HI:LEN_LO] = number of flits following flit1; tag = flit1[MSHRID_HI:MSHRID_LO].
  - flit2: address.
  - flit3: ignored.
  - len==2 is a read; len>2 is a write of len-2 data flits.
- States:
  - IDLE: rdy=1. On flit1 transfer latch len and tag, go to HDR2.
  - HDR2: rdy=1. On transfer latch ptr = word index; if len<2 go to IDLE (malformed, no response), else HDR3.
  - HDR3: rdy=1. On transfer: if len==2 go to RD_HDR, else remaining=len-2 and go to WR_DATA.
  - WR_DATA: rdy=1. Each transfer writes mem[ptr]=flit, ptr+=1 mod depth, remaining-=1. The transfer with remaining==1 goes to WR_ACK.
  - WR_ACK: rdy=0, val=1. Data = len field 0, tag field = tag, all other bits 0. On out transfer go to IDLE.
  - RD_HDR: rdy=0, val=1. Data = len field RD_DATA_FLITS, tag field = tag, other bits 0. On out transfer cnt=0, go to RD_DATA.
  - RD_DATA: rdy=0, val=1, data=mem[ptr]. On out transfer ptr+=1 mod depth, cnt+=1. The transfer with cnt==RD_DATA_FLITS-1 goes to IDLE.
- Malformed len==0: stay in IDLE after flit1 (packet fully consumed), no response.
- Latency: response header is valid the cycle after the flit3 (read) or last-data-flit (write) transfer. With rdy always high, next request flit1 is accepted the cycle after the last response flit transfers.
- Wrap-around: ptr wraps from 2^MEM_ADDR_WIDTH-1 to 0 for both reads and writes; address bits above the index are ignored.
- Backpressure: noc3_out_rdy=0 holds state, val, and data stable indefinitely. noc2_in_val=0 in any header or data state stalls without side effects.
- Request input is never accepted while a response is pending; no overlap or reordering; exactly one response per well-formed request.
- Reset mid-operation: immediate return to reset state. Words already written stay written; no partial response is emitted after reset.
- Widths: len and cnt 8 bits. ptr MEM_ADDR_WIDTH bits, modular arithmetic.

Test Plan:
1. Write then read: write, tag 0x15, addr 0x40, len=4, data A0,A1 -> WR_ACK flit with len 0, tag 0x15, mem[8]=A0, mem[9]=A1. Read of addr 0x40, tag 0x22 -> header len 32, tag 0x22, first two data flits A0,A1, then 30 more flits (mem[10..39]).
2. Wrap: write addr 0x7F8 (word 255), len=4, data B0,B1 -> mem[255]=B0, mem[0]=B1. Read at word 255 -> flits B0, B1, mem[1], ...
3. Backpressure: during read, hold noc3_out_rdy=0 for 5 cycles on the header and on data flit 3 -> val and data stable throughout; exactly 33 transfers total; busy deasserts the cycle after the last one.
4. Input stalls: noc2_in_val toggled 1/0 every cycle through a len=6 write -> 4 data words written in order to consecutive words; single ack; noc2_in_rdy=0 during ack.
5. Malformed: flit1 len=0 -> no response, back-to-back valid read accepted next cycle. len=1 -> two flits consumed, no response.
6. Reset: assert rst_n=0 in RD_DATA after 10 data flits -> noc3_out_val=0 immediately (asynchronous), busy=0, noc2_in_rdy=1 after release; subsequent read returns correct full burst.
